// File: rtl/ram_xs3_reader_pkg.sv
// Shared constants, FSM encoding and excess-3 helper for ram_xs3_reader.
// Imported by the interface, the storage block and the top.
package ram_xs3_reader_pkg;

   localparam int ADDR_W = 4;
   localparam int DATA_W = 8;

   localparam logic [7:0] XS3_OFFSET = 8'h03;
   localparam logic [7:0] XS3_MIN    = 8'h03;
   localparam logic [7:0] XS3_MAX    = 8'h0C;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      DRAIN = 2'd2,
      FIN   = 2'd3
   } state_t;

   function automatic logic xs3_legal(input logic [7:0] w);
      return (w >= XS3_MIN) && (w <= XS3_MAX);
   endfunction

endpackage

// File: rtl/ram_xs3_reader_if.sv
// Load port, scan request and decoded result bus of ram_xs3_reader.
// master: drives load/scan requests; slave: the reader itself.
interface ram_xs3_reader_if #(
   parameter int ADDR_W = ram_xs3_reader_pkg::ADDR_W,
   parameter int DATA_W = ram_xs3_reader_pkg::DATA_W
);
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              start;
   logic [ADDR_W-1:0] first_addr;
   logic [ADDR_W-1:0] last_addr;
   logic              busy;
   logic [3:0]        dout;
   logic              dout_valid;
   logic              code_err;
   logic [4:0]        err_count;
   logic              done;

   modport master (
      output wr_en, wr_addr, wr_data,
      output start, first_addr, last_addr,
      input  busy, dout, dout_valid,
      input  code_err, err_count, done
   );

   modport slave (
      input  wr_en, wr_addr, wr_data,
      input  start, first_addr, last_addr,
      output busy, dout, dout_valid,
      output code_err, err_count, done
   );
endinterface

// File: rtl/ram16x8_sync.sv
// 16x8 storage: one synchronous write port, one synchronous read port.
// Ports: clk, we/waddr/wdata (write), re/raddr/rdata (read, 1-cycle latency).
module ram16x8_sync #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   // Contents are not reset; a same-address read returns the old word.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/ram_xs3_reader.sv
// Scans an inclusive, wrapping address range of a 16x8 RAM and decodes
// excess-3 words. Ports: clk, rst_n (async, active-low), bus (slave).
module ram_xs3_reader #(
   parameter int ADDR_W = ram_xs3_reader_pkg::ADDR_W,
   parameter int DATA_W = ram_xs3_reader_pkg::DATA_W
) (
   input logic clk,
   input logic rst_n,
   ram_xs3_reader_if.slave bus
);
   import ram_xs3_reader_pkg::*;

   state_t            st;
   state_t            st_nx;
   logic [ADDR_W-1:0] rd_addr;
   logic [ADDR_W-1:0] last_q;
   logic              rvalid;
   logic [4:0]        err_q;
   logic [DATA_W-1:0] rdata;
   logic              legal;
   logic              bad;

   ram16x8_sync #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_ram (
      .clk   (clk),
      .we    (bus.wr_en),
      .waddr (bus.wr_addr),
      .wdata (bus.wr_data),
      .re    (st == SCAN),
      .raddr (rd_addr),
      .rdata (rdata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st      <= IDLE;
         rd_addr <= '0;
         last_q  <= '0;
         rvalid  <= 1'b0;
         err_q   <= '0;
      end else begin
         st     <= st_nx;
         // RAM data lands one cycle after each SCAN read
         rvalid <= (st == SCAN);
         if (st == IDLE && bus.start) begin
            rd_addr <= bus.first_addr;
            last_q  <= bus.last_addr;
            err_q   <= '0;
         end else if (st == SCAN) begin
            rd_addr <= rd_addr + 1'b1;
         end
         if (bad) err_q <= err_q + 5'd1;
      end
   end

   always_comb begin
      st_nx = st;
      unique case (st)
         IDLE:    if (bus.start) st_nx = SCAN;
         SCAN:    if (rd_addr == last_q) st_nx = DRAIN;
         DRAIN:   st_nx = FIN;
         FIN:     st_nx = IDLE;
         default: st_nx = IDLE;
      endcase
   end

   assign legal = xs3_legal(rdata);
   assign bad   = rvalid && !legal;

   assign bus.dout_valid = rvalid;
   assign bus.code_err   = bad;
   assign bus.dout       = (rvalid && legal) ? 4'(rdata - XS3_OFFSET) : 4'd0;
   // Include the word on the bus now so the count moves with dout_valid
   assign bus.err_count  = err_q + 5'(bad);
   assign bus.busy       = (st != IDLE);
   assign bus.done       = (st == FIN);

endmodule

// File: tb/tb_ram_xs3_reader.sv
// Self-checking bench for ram_xs3_reader against an array/queue model.
// Directed scenarios followed by randomized fills and scans.
module tb_ram_xs3_reader;

   logic clk;
   logic rst_n;
   int   tests;
   int   fails;
   logic [7:0] mem_m [16];

   ram_xs3_reader_if bus ();

   ram_xs3_reader dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [3:0] a, input logic [7:0] d);
      bus.wr_en   = 1'b1;
      bus.wr_addr = a;
      bus.wr_data = d;
      step();
      bus.wr_en   = 1'b0;
      mem_m[a]    = d;
   endtask

   function automatic logic [7:0] rnd_word();
      if ($urandom_range(9, 0) < 7)
         return 8'(3 + $urandom_range(9, 0));
      else if ($urandom_range(1, 0) == 0)
         return 8'($urandom_range(2, 0));
      else
         return 8'(13 + $urandom_range(242, 0));
   endfunction

   // Full scan with expected values built from the model memory.
   // pulse_at: index of valid cycle during which start is pulsed (-1: none).
   // coll: write 0x0C to first address in the cycle it is read.
   task automatic run_scan(input logic [3:0] f, input logic [3:0] l,
                           input int pulse_at, input bit coll,
                           input string tag);
      int         n;
      int         errs;
      logic [3:0] a;
      logic [7:0] w;
      logic [3:0] ed[$];
      bit         ee[$];
      n = int'(4'(l - f)) + 1;
      for (int k = 0; k < n; k++) begin
         a = f + 4'(k);
         w = mem_m[a];
         if (w >= 8'd3 && w <= 8'd12) begin
            ed.push_back(4'(w - 8'd3));
            ee.push_back(1'b0);
         end else begin
            ed.push_back(4'd0);
            ee.push_back(1'b1);
         end
      end
      bus.first_addr = f;
      bus.last_addr  = l;
      bus.start      = 1'b1;
      step();
      bus.start      = 1'b0;
      bus.first_addr = 4'($urandom);
      bus.last_addr  = 4'($urandom);
      if (coll) begin
         bus.wr_en   = 1'b1;
         bus.wr_addr = f;
         bus.wr_data = 8'h0C;
      end
      chk({tag, "_c1_busy"}, 32'(bus.busy), 32'd1);
      chk({tag, "_c1_valid"}, 32'(bus.dout_valid), 32'd0);
      errs = 0;
      for (int k = 0; k < n; k++) begin
         step();
         if (k == 0 && coll) begin
            bus.wr_en = 1'b0;
            mem_m[f]  = 8'h0C;
         end
         bus.start = (k == pulse_at);
         if (ee[k]) errs++;
         chk({tag, "_valid"}, 32'(bus.dout_valid), 32'd1);
         chk({tag, "_dout"}, 32'(bus.dout), 32'(ed[k]));
         chk({tag, "_cerr"}, 32'(bus.code_err), 32'(ee[k]));
         chk({tag, "_errcnt"}, 32'(bus.err_count), 32'(errs));
         chk({tag, "_done_early"}, 32'(bus.done), 32'd0);
      end
      bus.start = 1'b0;
      step();
      chk({tag, "_done"}, 32'(bus.done), 32'd1);
      chk({tag, "_fin_valid"}, 32'(bus.dout_valid), 32'd0);
      chk({tag, "_fin_dout"}, 32'(bus.dout), 32'd0);
      chk({tag, "_fin_busy"}, 32'(bus.busy), 32'd1);
      step();
      chk({tag, "_idle_done"}, 32'(bus.done), 32'd0);
      chk({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
      chk({tag, "_hold_errcnt"}, 32'(bus.err_count), 32'(errs));
   endtask

   initial begin
      int f;
      int l;
      int n;
      tests          = 0;
      fails          = 0;
      rst_n          = 1'b0;
      bus.wr_en      = 1'b0;
      bus.wr_addr    = '0;
      bus.wr_data    = '0;
      bus.start      = 1'b0;
      bus.first_addr = '0;
      bus.last_addr  = '0;
      step();
      step();
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_valid", 32'(bus.dout_valid), 32'd0);
      chk("rst_dout", 32'(bus.dout), 32'd0);
      chk("rst_cerr", 32'(bus.code_err), 32'd0);
      chk("rst_errcnt", 32'(bus.err_count), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      rst_n = 1'b1;
      step();

      // Legal digits 0..9, remaining addresses legal too
      for (int i = 0; i < 16; i++) wr(4'(i), 8'(3 + (i % 10)));
      run_scan(4'd0, 4'd9, -1, 1'b0, "digits");

      // Two illegal words inside the range
      wr(4'd2, 8'h00);
      wr(4'd4, 8'hFF);
      run_scan(4'd0, 4'd5, -1, 1'b0, "errs");

      // Wrapping range
      run_scan(4'd14, 4'd1, -1, 1'b0, "wrap");

      // Single word
      wr(4'd7, 8'h08);
      run_scan(4'd7, 4'd7, -1, 1'b0, "single");

      // Start pulsed mid-scan is ignored
      run_scan(4'd3, 4'd11, 2, 1'b0, "midstart");

      // Write collides with read: old word first, new word on rescan
      wr(4'd5, 8'h04);
      run_scan(4'd5, 4'd5, -1, 1'b1, "coll");
      run_scan(4'd5, 4'd5, -1, 1'b0, "rescan");

      // Asynchronous reset mid-scan
      bus.first_addr = 4'd0;
      bus.last_addr  = 4'd15;
      bus.start      = 1'b1;
      step();
      bus.start = 1'b0;
      step();
      step();
      step();
      #2 rst_n = 1'b0;
      #1;
      chk("arst_busy", 32'(bus.busy), 32'd0);
      chk("arst_valid", 32'(bus.dout_valid), 32'd0);
      chk("arst_dout", 32'(bus.dout), 32'd0);
      chk("arst_cerr", 32'(bus.code_err), 32'd0);
      chk("arst_errcnt", 32'(bus.err_count), 32'd0);
      chk("arst_done", 32'(bus.done), 32'd0);
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step();
         chk("arst_nodone", 32'(bus.done), 32'd0);
      end
      chk("arst_idle", 32'(bus.busy), 32'd0);
      // Memory survives reset
      run_scan(4'd0, 4'd15, -1, 1'b0, "postrst");

      // Randomized fills and scans
      for (int r = 0; r < 8; r++) begin
         for (int i = 0; i < 16; i++) wr(4'(i), rnd_word());
         f = int'($urandom_range(15, 0));
         l = int'($urandom_range(15, 0));
         n = ((l - f + 16) % 16) + 1;
         run_scan(4'(f), 4'(l),
                  ($urandom_range(1, 0) == 1) ?
                     int'($urandom_range(32'(n - 1), 0)) : -1,
                  1'b0, "rand");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/ram_xs3_reader.md
RAM_XS3_READER -- requirements
Module: ram_xs3_reader

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 4, meaning address width (fixed depth 16).
REQ-002 The block SHALL have parameter DATA_W, default 8, meaning stored word width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port wr_en, input, 1 bit: write strobe for the load port.
REQ-006 The block SHALL have port wr_addr, input, 4 bits: write address.
REQ-007 The block SHALL have port wr_data, input, 8 bits: excess-3 word to store.
REQ-008 The block SHALL have port start, input, 1 bit: request a read scan.
REQ-009 The block SHALL have ports first_addr and last_addr, input, 4 bits each: inclusive scan bounds.
REQ-010 The block SHALL have port busy, output, 1 bit: scan in progress.
REQ-011 The block SHALL have port dout, output, 4 bits: decoded binary digit.
REQ-012 The block SHALL have port dout_valid, output, 1 bit: dout/code_err qualify this cycle.
REQ-013 The block SHALL have port code_err, output, 1 bit: current word is not a legal excess-3 code.
REQ-014 The block SHALL have port err_count, output, 5 bits: illegal words seen in the current or last scan.
REQ-015 The block SHALL have port done, output, 1 bit: one-cycle end-of-scan pulse.

Function
REQ-016 Storage SHALL be 16x8, synchronous write when wr_en=1, write allowed in any state.
REQ-017 Reads SHALL be synchronous, one-cycle latency; same-address read and write in one cycle SHALL return the old word.
REQ-018 FSM states SHALL be IDLE, SCAN, DRAIN, FIN.
REQ-019 IDLE: start=1 SHALL latch first_addr/last_addr, load rd_addr=first_addr, clear err_count, go SCAN.
REQ-020 SCAN: one read per cycle; rd_addr SHALL increment mod 16 (15 wraps to 0); on reading last_addr go DRAIN.
REQ-021 Word count SHALL be ((last_addr - first_addr) mod 16) + 1; first_addr=last_addr reads exactly one word.
REQ-022 DRAIN: one cycle for the last read data, then FIN; FIN asserts done for one cycle, then IDLE.
REQ-023 dout_valid SHALL first assert 2 cycles after the start edge and stay high for exactly word-count consecutive cycles.
REQ-024 done SHALL assert the cycle after the last dout_valid; busy SHALL be high from the cycle after start through the done cycle.
REQ-025 Decode: words 0x03..0x0C SHALL give dout = word - 3, code_err=0.
REQ-026 Any other word SHALL give dout=0, code_err=1, and err_count+1 in the same cycle dout_valid is high.
REQ-027 start while busy SHALL be ignored; first/last changes during a scan SHALL have no effect.
REQ-028 err_count SHALL hold its value after done until the next accepted start.
REQ-029 When dout_valid=0, dout and code_err SHALL be 0.

Reset
REQ-030 rst_n=0 SHALL immediately force IDLE, busy=0, dout=0, dout_valid=0, code_err=0, err_count=0, done=0.
REQ-031 Reset mid-scan SHALL abort with no done pulse; memory contents SHALL NOT be reset.

Structure
REQ-032 A shared package SHALL hold ADDR_W, DATA_W, XS3_OFFSET=3, XS3_MIN=0x03, XS3_MAX=0x0C, and the FSM state encoding.
REQ-033 Storage SHALL be one sub-module, ram16x8_sync (dual-address: write port, read port), instantiated once.

Verification
REQ-034 Write 0x03..0x0C at addr 0..9, start first=0,last=9 -> dout 0..9 on 10 consecutive valid cycles, err_count=0, done once.
REQ-035 Write 0x00 at addr 2 and 0xFF at addr 4, scan 0..5 -> code_err at words 2 and 4 with dout=0, err_count=2.
REQ-036 Scan first=14,last=1 -> addresses 14,15,0,1 in order, 4 valid cycles.
REQ-037 first=last=7 holding 0x08 -> single valid cycle, dout=5, done the next cycle.
REQ-038 start pulsed mid-scan -> ignored, word count unchanged; rst_n low mid-scan -> outputs 0 immediately, no done.
REQ-039 Write 0x0C to the address being read in the same cycle -> old word returned; rescan returns dout=9.
